// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-expansion engine.
//   nr()      : number of cipher rounds for a key of nk 32-bit words
//   RCON_INIT : first round constant
//   xtime()   : GF(2^8) multiply-by-two, used to step the round constant
//   state_t   : expansion controller states
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int nr(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subbytes.sv
// AES SubBytes applied to one 32-bit word (four independent S-box lookups).
// Purely combinational.
//   i_word : input word
//   o_word : S-box substituted word, byte lanes preserved
module aes_subbytes (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Entry 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    o_word = '0;
    for (int k = 0; k < 4; k++) begin
      o_word[8*k +: 8] = SBOX[i_word[8*k +: 8]];
    end
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion: one 32-bit word per cycle into an internal
// round-key store, with a registered 128-bit round-key read port.
//   clk, rst  : clock, synchronous active-high reset
//   key_in    : cipher key, w[0] in the MSBs (32*NK bits)
//   key_valid : key_in valid; accepted when key_ready is high
//   key_ready : high in IDLE and DONE
//   done      : full round-key set available (registered)
//   rk_sel    : round-key index 0..NR; larger values read as zero
//   rk_out    : registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32*NK-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              done,
  input  logic [3:0]        rk_sel,
  output logic [127:0]      rk_out
);

  localparam int            NR   = nr(NK);
  localparam int            NW   = 4 * (NR + 1);
  localparam int            IW   = $clog2(NW);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  localparam logic [3:0]    NR4  = 4'(NR);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_w [NW];
  logic [IW-1:0] r_i;
  logic [7:0]    r_rcon;
  logic [2:0]    r_phase;
  logic          r_done;
  logic [127:0]  r_rk_out;

  logic          w_accept;
  logic          w_last;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_rot;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic [IW-1:0] w_rk_base;

  assign w_accept = key_valid & key_ready;
  assign w_last   = (r_i == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a key arriving during EXPAND is simply not accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_accept) w_state_nxt = EXPAND;
      EXPAND:     if (w_last)   w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    key_ready = (r_state == IDLE) || (r_state == DONE);
  end

  // Expansion counters: word index, round constant and position within an NK group
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i     <= '0;
      r_rcon  <= RCON_INIT;
      r_phase <= '0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      r_i     <= IW'(NK);
      r_rcon  <= RCON_INIT;
      r_phase <= '0;
      r_done  <= 1'b0;
    end else if (r_state == EXPAND) begin
      r_i     <= r_i + IW'(1);
      r_phase <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
      if (r_phase == 3'd0) r_rcon <= xtime(r_rcon);
      if (w_last)          r_done <= 1'b1;
    end
  end

  // Word generation: a single SubWord instance, fed RotWord(temp) at the start
  // of each group and plain temp at the AES-256 mid-group position.
  assign w_prev   = r_w[r_i - IW'(1)];
  assign w_back   = r_w[r_i - IW'(NK)];
  assign w_rot    = {w_prev[23:0], w_prev[31:24]};
  assign w_sub_in = (r_phase == 3'd0) ? w_rot : w_prev;

  aes_subbytes u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_phase == 3'd0)                      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if ((NK == 8) && (r_phase == 3'd4))  w_temp = w_sub_out;
  end

  assign w_new = w_back ^ w_temp;

  // Word store, not reset; a key presented together with rst is not captured
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      for (int k = 0; k < NK; k++) begin
        r_w[k] <= key_in[32*(NK-1-k) +: 32];
      end
    end else if (r_state == EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  // Read port: one-cycle latency, out-of-range indices read as zero
  assign w_rk_base = IW'({rk_sel, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rk_out <= '0;
    end else if (rk_sel > NR4) begin
      r_rk_out <= '0;
    end else begin
      r_rk_out <= {r_w[w_rk_base],          r_w[w_rk_base + IW'(1)],
                   r_w[w_rk_base + IW'(2)], r_w[w_rk_base + IW'(3)]};
    end
  end

  assign done   = r_done;
  assign rk_out = r_rk_out;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule with one AES-128 and one AES-256 instance.
module tb_aes_key_schedule;

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk;
  logic         rst;
  logic [127:0] k128;
  logic         kv128;
  logic         ready128;
  logic         done128;
  logic [3:0]   sel128;
  logic [127:0] rk128;
  logic [255:0] k256;
  logic         kv256;
  logic         ready256;
  logic         done256;
  logic [3:0]   sel256;
  logic [127:0] rk256;

  int n_checks;
  int n_pass;
  int cycles;

  aes_key_schedule #(.NK(4)) u128 (
    .clk(clk), .rst(rst), .key_in(k128), .key_valid(kv128),
    .key_ready(ready128), .done(done128), .rk_sel(sel128), .rk_out(rk128)
  );

  aes_key_schedule #(.NK(8)) u256 (
    .clk(clk), .rst(rst), .key_in(k256), .key_valid(kv256),
    .key_ready(ready256), .done(done256), .rk_sel(sel256), .rk_out(rk256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    k128 = '0; kv128 = 1'b0; sel128 = 4'd15;
    k256 = '0; kv256 = 1'b0; sel256 = 4'd15;

    // Reset state
    tick();
    tick();
    check("rst_ready128", 128'(ready128), 128'd1);
    check("rst_done128",  128'(done128),  128'd0);
    check("rst_rk128",    rk128,          128'd0);
    check("rst_ready256", 128'(ready256), 128'd1);
    check("rst_done256",  128'(done256),  128'd0);
    check("rst_rk256",    rk256,          128'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready128", 128'(ready128), 128'd1);

    // AES-128 A.1, with an ignored key pulse in the middle of expansion
    k128 = KEY128; kv128 = 1'b1;
    tick();
    kv128 = 1'b0;
    check("a128_busy_ready", 128'(ready128), 128'd0);
    check("a128_busy_done",  128'(done128),  128'd0);
    cycles = 1;
    while (!done128 && cycles < 200) begin
      if (cycles == 10) begin k128 = '0; kv128 = 1'b1; end
      else kv128 = 1'b0;
      tick();
      cycles++;
    end
    kv128 = 1'b0;
    check("a128_latency",    128'(cycles),   128'd41);
    check("a128_done_ready", 128'(ready128), 128'd1);
    sel128 = 4'd1;  tick(); check("a128_rk1",  rk128, 128'ha0fafe1788542cb123a339392a6c7605);
    sel128 = 4'd10; tick(); check("a128_rk10", rk128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sel128 = 4'd0;  tick(); check("a128_rk0",  rk128, KEY128);
    sel128 = 4'd11; tick(); check("a128_rk11_oor", rk128, 128'd0);
    sel128 = 4'd15; tick(); check("a128_rk15_oor", rk128, 128'd0);

    // AES-256 A.3
    k256 = KEY256; kv256 = 1'b1;
    tick();
    kv256 = 1'b0;
    check("a256_busy_ready", 128'(ready256), 128'd0);
    cycles = 1;
    while (!done256 && cycles < 200) begin
      tick();
      cycles++;
    end
    check("a256_latency", 128'(cycles), 128'd53);
    sel256 = 4'd1;  tick(); check("a256_rk1", rk256, KEY256[127:0]);
    sel256 = 4'd2;  tick(); check("a256_w8",  128'(rk256[127:96]), 128'h9ba35411);
    sel256 = 4'd3;  tick(); check("a256_w12", 128'(rk256[127:96]), 128'ha8b09c1a);
    sel256 = 4'd14; tick(); check("a256_rk14", rk256, 128'hfe4890d1e6188d0b046df344706c631e);
    sel256 = 4'd15; tick(); check("a256_rk15_oor", rk256, 128'd0);

    // Reset in the middle of an AES-128 expansion, with a key offered alongside rst
    k128 = KEY128; kv128 = 1'b1;
    tick();
    kv128 = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("mid_busy_ready", 128'(ready128), 128'd0);
    rst = 1'b1; kv128 = 1'b1;
    tick();
    rst = 1'b0; kv128 = 1'b0;
    check("mid_rst_ready128", 128'(ready128), 128'd1);
    check("mid_rst_done128",  128'(done128),  128'd0);
    check("mid_rst_done256",  128'(done256),  128'd0);

    // Re-run A.1 after the abort
    k128 = KEY128; kv128 = 1'b1;
    tick();
    kv128 = 1'b0;
    cycles = 1;
    while (!done128 && cycles < 200) begin
      tick();
      cycles++;
    end
    check("rerun_latency", 128'(cycles), 128'd41);

    // Back-to-back: all-zero key on the first DONE cycle; the read on the
    // acceptance edge still sees the rerun's round key 10.
    k128 = '0; kv128 = 1'b1; sel128 = 4'd10;
    tick();
    kv128 = 1'b0;
    check("b2b_done_drop", 128'(done128), 128'd0);
    check("rerun_rk10",    rk128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    cycles = 1;
    while (!done128 && cycles < 200) begin
      tick();
      cycles++;
    end
    check("b2b_latency", 128'(cycles), 128'd41);
    tick();
    check("b2b_rk10", rk128, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    sel128 = 4'd0; tick(); check("b2b_rk0", rk128, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
